// File: rtl/sequenciador_funcionalidades_pkg.sv
// sequenciador_funcionalidades_pkg: shared states, grant field layout and counter width
package sequenciador_funcionalidades_pkg;
  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;
  localparam int FIELD_W = 3;
  localparam int IE01_PROF = 0;
  localparam int IE01_FUNC = 3;
  localparam int IE02_PROF = 6;
  localparam int IE02_FUNC = 9;
  localparam int CNT_W = 8;
  function automatic logic one_hot3(input logic [FIELD_W-1:0] v);
    return v == 3'b001 || v == 3'b010 || v == 3'b100;
  endfunction
endpackage

// File: rtl/sequenciador_funcionalidades_seletor.sv
// seletor_pendente: picks the lowest pending bit and splits it into owner and functionality id
module seletor_pendente
  import sequenciador_funcionalidades_pkg::*;
(
  input  logic [2*FIELD_W-1:0] mask,
  output logic                 valid,
  output logic                 owner,
  output logic [1:0]           id
);
  logic [2:0] idx;
  always_comb begin
    idx = 3'd0;
    for (int i = 2*FIELD_W-1; i >= 0; i--) idx = mask[i] ? 3'(i) : idx;
  end
  assign valid = |mask;
  assign owner = idx >= 3'd3;
  assign id = owner ? 2'(idx - 3'd3) : idx[1:0];
endmodule

// File: rtl/sequenciador_funcionalidades.sv
// sequenciador_funcionalidades: serializes a granted word into per-functionality requests with ack/timeout
module sequenciador_funcionalidades
  import sequenciador_funcionalidades_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [11:0]      grant,
  output logic             req_ready,
  output logic             func_valid,
  output logic             func_owner,
  output logic [1:0]       func_id,
  output logic [2:0]       func_profile,
  input  logic             func_ack,
  output logic             done,
  output logic [CNT_W-1:0] count_ie01,
  output logic [CNT_W-1:0] count_ie02,
  output logic             timeout_err,
  output logic             prof_err
);
  state_t state, state_nxt;
  logic [5:0] mask, cap_mask, item_bit;
  logic [2:0] prof01, prof02;
  logic [7:0] wait_cnt;
  logic [1:0] acked;
  logic sel_valid, sel_owner, accept, ok01, ok02, expire, drop;
  logic [1:0] sel_id;
  seletor_pendente u_sel (.mask(mask), .valid(sel_valid), .owner(sel_owner), .id(sel_id));
  assign req_ready = state == IDLE;
  assign func_valid = state == SERVE && sel_valid;
  assign done = state == DONE;
  assign accept = req_valid && req_ready;
  assign func_owner = func_valid && sel_owner;
  assign func_id = func_valid ? sel_id : 2'd0;
  assign func_profile = !func_valid ? 3'd0 : sel_owner ? prof02 : prof01;
  assign ok01 = grant[IE01_FUNC +: FIELD_W] == '0 || one_hot3(grant[IE01_PROF +: FIELD_W]);
  assign ok02 = grant[IE02_FUNC +: FIELD_W] == '0 || one_hot3(grant[IE02_PROF +: FIELD_W]);
  assign cap_mask = {ok02 ? grant[IE02_FUNC +: FIELD_W] : 3'd0, ok01 ? grant[IE01_FUNC +: FIELD_W] : 3'd0};
  assign item_bit = mask & (~mask + 6'd1);
  assign expire = wait_cnt == 8'(TIMEOUT - 1);
  assign drop = func_valid && (func_ack || expire);
  always_comb
    state_nxt = state == IDLE ? (accept ? (|cap_mask ? SERVE : DONE) : IDLE)
              : state == SERVE ? (drop && ~|(mask & ~item_bit) ? DONE : SERVE)
              : IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mask <= '0;
      prof01 <= '0;
      prof02 <= '0;
      wait_cnt <= '0;
      acked <= '0;
      count_ie01 <= '0;
      count_ie02 <= '0;
      timeout_err <= 1'b0;
      prof_err <= 1'b0;
    end else begin
      state <= state_nxt;
      mask <= accept ? cap_mask : drop ? mask & ~item_bit : mask;
      wait_cnt <= (drop || !func_valid) ? 8'd0 : wait_cnt + 8'd1;
      if (accept) begin
        prof01 <= grant[IE01_PROF +: FIELD_W];
        prof02 <= grant[IE02_PROF +: FIELD_W];
        acked <= '0;
        prof_err <= prof_err | ~ok01 | ~ok02;
      end
      if (drop && func_ack) acked[sel_owner] <= 1'b1;
      if (drop && !func_ack) timeout_err <= 1'b1;
      if (done && acked[0] && count_ie01 != '1) count_ie01 <= count_ie01 + 8'd1;
      if (done && acked[1] && count_ie02 != '1) count_ie02 <= count_ie02 + 8'd1;
    end
  end
endmodule

// File: tb/tb_sequenciador_funcionalidades.sv
// tb_sequenciador_funcionalidades: directed and randomized checks against a word-level reference model
module tb_sequenciador_funcionalidades;
  localparam int TIMEOUT = 3;
  logic clk = 1'b0;
  logic reset, req_valid, func_ack;
  logic [11:0] grant;
  logic req_ready, func_valid, func_owner, done, timeout_err, prof_err;
  logic [1:0] func_id;
  logic [2:0] func_profile;
  logic [7:0] count_ie01, count_ie02;
  int n_chk, n_pass, n_fail, exp01, exp02;
  int delay[6];
  bit eterr, eperr;
  sequenciador_funcionalidades #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .grant(grant),
    .req_ready(req_ready), .func_valid(func_valid), .func_owner(func_owner),
    .func_id(func_id), .func_profile(func_profile), .func_ack(func_ack),
    .done(done), .count_ie01(count_ie01), .count_ie02(count_ie02),
    .timeout_err(timeout_err), .prof_err(prof_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_quiet_idle();
    chk("req_ready", req_ready, 1);
    chk("func_valid", func_valid, 0);
    chk("func_owner", func_owner, 0);
    chk("func_id", func_id, 0);
    chk("func_profile", func_profile, 0);
    chk("done", done, 0);
    chk("count_ie01", count_ie01, exp01);
    chk("count_ie02", count_ie02, exp02);
    chk("timeout_err", timeout_err, eterr);
    chk("prof_err", prof_err, eperr);
  endtask
  task automatic run_word(input logic [11:0] g);
    int own[$], fid[$], prf[$];
    bit acked[2];
    acked[0] = 0;
    acked[1] = 0;
    for (int s = 0; s < 2; s++) begin
      logic [2:0] p, f;
      p = g[6*s +: 3];
      f = g[6*s+3 +: 3];
      if (f != 3'd0 && $countones(p) != 1) eperr = 1;
      else for (int i = 0; i < 3; i++)
        if (f[i]) begin
          own.push_back(s);
          fid.push_back(i);
          prf.push_back(int'(p));
        end
    end
    chk("req_ready_before", req_ready, 1);
    req_valid = 1;
    grant = g;
    step();
    req_valid = 0;
    grant = 12'($urandom);
    for (int k = 0; k < own.size(); k++) begin
      for (int c = 0; c < TIMEOUT; c++) begin
        chk("func_valid", func_valid, 1);
        chk("func_owner", func_owner, own[k]);
        chk("func_id", func_id, fid[k]);
        chk("func_profile", func_profile, prf[k]);
        chk("req_ready_busy", req_ready, 0);
        chk("done_busy", done, 0);
        func_ack = (c == delay[k]);
        step();
        func_ack = 0;
        if (c == delay[k]) break;
      end
      if (delay[k] < TIMEOUT) acked[own[k]] = 1;
      else eterr = 1;
    end
    chk("done_pulse", done, 1);
    chk("func_valid_done", func_valid, 0);
    if (acked[0] && exp01 < 255) exp01++;
    if (acked[1] && exp02 < 255) exp02++;
    step();
    chk_quiet_idle();
  endtask
  initial begin
    reset = 1;
    req_valid = 0;
    func_ack = 0;
    grant = '0;
    step();
    step();
    chk_quiet_idle();
    reset = 0;
    step();
    chk_quiet_idle();
    delay = '{0, 0, 0, 0, 0, 0};
    run_word(12'b000_000_011_001);
    run_word(12'b101_100_110_010);
    delay[0] = TIMEOUT;
    run_word(12'b001_001_000_000);
    run_word(12'b000_000_001_011);
    for (int w = 0; w < 40; w++) begin
      logic [11:0] g;
      g = 12'($urandom);
      for (int s = 0; s < 2; s++)
        if ($urandom_range(0, 4) != 0) g[6*s +: 3] = 3'(1 << $urandom_range(0, 2));
      for (int k = 0; k < 6; k++) delay[k] = $urandom_range(0, TIMEOUT);
      run_word(g);
    end
    func_ack = 1;
    step();
    step();
    func_ack = 0;
    chk_quiet_idle();
    req_valid = 1;
    grant = 12'b000_000_011_001;
    step();
    req_valid = 0;
    func_ack = 1;
    step();
    func_ack = 0;
    chk("second_item_id", func_id, 1);
    reset = 1;
    step();
    exp01 = 0;
    exp02 = 0;
    eterr = 0;
    eperr = 0;
    chk_quiet_idle();
    reset = 0;
    step();
    chk_quiet_idle();
    delay = '{0, 0, 0, 0, 0, 0};
    for (int w = 0; w < 260; w++) run_word(12'b000_000_001_010);
    chk("count_ie01_sat", count_ie01, 255);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sequenciador_funcionalidades.md
SEQUENCIADOR_FUNCIONALIDADES -- requirements
Module: sequenciador_funcionalidades

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-high reset; every register SHALL update only on the rising clk edge.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the number of cycles to wait for func_ack per item (range 1..255).
REQ-003 clk  in  1  system clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  grant word present.
REQ-006 grant  in  12  priority-controller output: [2:0] IE01 profile one-hot, [5:3] IE01 functionalities, [8:6] IE02 profile one-hot, [11:9] IE02 functionalities.
REQ-007 req_ready  out  1  block can accept a grant word.
REQ-008 func_valid  out  1  one functionality request is presented.
REQ-009 func_owner  out  1  0 = IE01, 1 = IE02.
REQ-010 func_id  out  2  functionality index 0..2.
REQ-011 func_profile  out  3  owner's one-hot profile.
REQ-012 func_ack  in  1  downstream has consumed the presented item.
REQ-013 done  out  1  one-cycle pulse when a word is fully processed.
REQ-014 count_ie01, count_ie02  out  8 each  words served per IE, saturating.
REQ-015 timeout_err, prof_err  out  1 each  sticky error flags.

Function
REQ-016 States SHALL be IDLE, SERVE, DONE; req_ready SHALL be 1 only in IDLE.
REQ-017 On req_valid && req_ready, the block SHALL capture grant and build a 6-bit pending mask {grant[11:9], grant[5:3]}.
REQ-018 If a side's functionality bits are nonzero and its profile field is not exactly one-hot, that side's pending bits SHALL be cleared at capture and prof_err SHALL be set.
REQ-019 After capture, the block SHALL go to SERVE if the mask is nonzero, else to DONE.
REQ-020 In SERVE, func_valid SHALL be 1 and present the lowest set mask bit (IE01 func 0,1,2 before IE02 func 0,1,2); the first item SHALL appear the cycle after acceptance.
REQ-021 Presented fields SHALL stay stable until func_ack or timeout.
REQ-022 On func_ack while func_valid, the presented bit SHALL clear; the next item SHALL be presented the following cycle; with no bits left, the block SHALL go to DONE and func_valid SHALL drop.
REQ-023 func_ack while func_valid = 0 SHALL be ignored.
REQ-024 A wait counter SHALL reset on each new item. If TIMEOUT cycles pass without func_ack, the item SHALL be dropped as if acknowledged and timeout_err SHALL be set.
REQ-025 In DONE, done SHALL pulse for exactly one cycle and the FSM SHALL return to IDLE the next cycle.
REQ-026 In DONE, each side with at least one acknowledged item SHALL increment its counter by 1, saturating at 255; timed-out items SHALL NOT count.
REQ-027 If func_ack and timeout expiry occur in the same cycle, the ack SHALL win: the item counts and no error is set.
REQ-028 A grant word with both sides nonempty SHALL be served in a single pass, IE01 items first.

Reset
REQ-029 Reset SHALL force IDLE and set req_ready = 1; func_valid, done, func_owner, func_id, func_profile, both counters and both error flags SHALL be 0; the mask and wait counter SHALL be cleared.
REQ-030 Reset asserted mid-SERVE SHALL abandon the word without a done pulse or counter update.

Structure
REQ-031 A shared package SHALL hold the state enum, the grant field offsets/widths, and the counter width (8).
REQ-032 The lowest-set-bit selection over the 6-bit mask SHALL be one sub-module, seletor_pendente (mask in; valid, owner, id out).

Verification
REQ-033 grant = 12'b000_000_011_001 (IE01 profile A, functionalities 0,1), ack held at 1 -> items (0,0),(0,1) on consecutive cycles, done, count_ie01 = 1.
REQ-034 grant = 12'b101_100_110_010 -> items IE01 func 1,2 then IE02 func 0,2; both counters = 1.
REQ-035 TIMEOUT = 3, grant IE02 func 0 only, no ack -> func_valid high 3 cycles, timeout_err = 1, done, count_ie02 = 0.
REQ-036 IE01 profile 3'b011 with func 0 set -> prof_err = 1, no func_valid, done pulse on the cycle after acceptance.
REQ-037 Reset asserted during the second item -> all outputs 0 next cycle, req_ready = 1, no done pulse.
REQ-038 260 single-item IE01 words -> count_ie01 saturates at 255.
